// File: rtl/game_key_ctrl_if.sv
// Key-scanner-to-game-controller bus: press/frame/miss pulses in, paddle and game status out.
interface game_key_ctrl_if;
  logic [3:0] key_pulse;
  logic       frame_tick;
  logic       ball_miss;
  logic [9:0] paddle_x;
  logic [1:0] game_state;
  logic       run_en;
  logic [1:0] lives;

  modport master (
    output key_pulse, frame_tick, ball_miss,
    input  paddle_x, game_state, run_en, lives
  );

  modport slave (
    input  key_pulse, frame_tick, ball_miss,
    output paddle_x, game_state, run_en, lives
  );
endinterface

// File: rtl/game_key_ctrl.sv
// Game-mode FSM, lives counter and per-frame paddle glide driven by key-press pulses.
// Optional macro PADDLE_ACCEL_EN: a repeated same-direction press within ACCEL_WIN frames steps 2*STEP.
module game_key_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int PADDLE_W  = 80,
  parameter int STEP      = 16,
  parameter int GLIDE     = 4,
  parameter int LIVES     = 3,
  parameter int ACCEL_WIN = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  game_key_ctrl_if.slave bus
);

  localparam logic [9:0]        X_MAX   = 10'(H_ACTIVE - PADDLE_W);
  localparam logic [9:0]        X_MID   = 10'((H_ACTIVE - PADDLE_W) / 2);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] GLIDE_S = 11'(GLIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e              state_r, state_nxt_s;
  logic [1:0]          lives_r, lives_nxt_s;
  logic [9:0]          target_r, target_nxt_s;
  logic [9:0]          paddle_r, paddle_nxt_s;
  logic                run_en_r;
  logic                left_s, right_s, start_s, restart_s;
  logic                press_ok_s, go_left_s, go_right_s;
  logic signed [10:0]  step_s, sum_s, diff_s;

  assign left_s    = bus.key_pulse[0];
  assign right_s   = bus.key_pulse[1];
  assign start_s   = bus.key_pulse[2];
  assign restart_s = bus.key_pulse[3];

  // Presses only count in PLAY when no higher-priority event is present this cycle.
  assign press_ok_s = (state_r == S_PLAY) && !restart_s && !start_s && !bus.ball_miss;
  assign go_left_s  = press_ok_s && left_s && !right_s;
  assign go_right_s = press_ok_s && right_s && !left_s;

`ifdef PADDLE_ACCEL_EN
  localparam int CW = $clog2(ACCEL_WIN + 1);
  logic [CW-1:0] accel_cnt_r;
  logic          chain_r;
  logic          last_right_r;

  // Doubled step when repeating the previous direction inside the window.
  always_comb begin
    step_s = STEP_S;
    if (chain_r && (accel_cnt_r < CW'(ACCEL_WIN)) && (last_right_r == go_right_s)) begin
      step_s = STEP_S + STEP_S;
    end else begin
      step_s = STEP_S;
    end
  end

  // Frame counter and last-direction memory for press acceleration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accel_cnt_r  <= '0;
      chain_r      <= 1'b0;
      last_right_r <= 1'b0;
    end else if (restart_s || (state_nxt_s != S_PLAY)) begin
      accel_cnt_r  <= '0;
      chain_r      <= 1'b0;
      last_right_r <= 1'b0;
    end else if (go_left_s || go_right_s) begin
      accel_cnt_r  <= '0;
      chain_r      <= 1'b1;
      last_right_r <= go_right_s;
    end else if (bus.frame_tick && (accel_cnt_r < CW'(ACCEL_WIN))) begin
      accel_cnt_r  <= accel_cnt_r + CW'(1);
    end
  end
`else
  assign step_s = STEP_S;
`endif

  // Game-mode transitions and lives bookkeeping in priority order.
  always_comb begin
    state_nxt_s = state_r;
    lives_nxt_s = lives_r;
    if (restart_s) begin
      state_nxt_s = S_IDLE;
      lives_nxt_s = 2'(LIVES);
    end else if (start_s) begin
      case (state_r)
        S_IDLE:  state_nxt_s = S_PLAY;
        S_PLAY:  state_nxt_s = S_PAUSE;
        S_PAUSE: state_nxt_s = S_PLAY;
        S_OVER:  state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end else if (bus.ball_miss && (state_r == S_PLAY)) begin
      if (lives_r <= 2'd1) begin
        state_nxt_s = S_OVER;
        lives_nxt_s = 2'd0;
      end else begin
        lives_nxt_s = lives_r - 2'd1;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Clamped target update and glide of paddle_x toward the previous target.
  always_comb begin
    target_nxt_s = target_r;
    paddle_nxt_s = paddle_r;
    sum_s  = go_left_s ? ($signed({1'b0, target_r}) - step_s)
                       : ($signed({1'b0, target_r}) + step_s);
    diff_s = $signed({1'b0, target_r}) - $signed({1'b0, paddle_r});
    if (restart_s) begin
      target_nxt_s = X_MID;
    end else if (go_left_s) begin
      target_nxt_s = (sum_s < 11'sd0) ? 10'd0 : sum_s[9:0];
    end else if (go_right_s) begin
      target_nxt_s = (sum_s > $signed({1'b0, X_MAX})) ? X_MAX : sum_s[9:0];
    end else begin
      target_nxt_s = target_r;
    end
    if (restart_s) begin
      paddle_nxt_s = X_MID;
    end else if (bus.frame_tick && (state_r == S_PLAY)) begin
      if (diff_s > GLIDE_S) begin
        paddle_nxt_s = paddle_r + 10'(GLIDE);
      end else if (diff_s < -GLIDE_S) begin
        paddle_nxt_s = paddle_r - 10'(GLIDE);
      end else begin
        paddle_nxt_s = target_r;
      end
    end else begin
      paddle_nxt_s = paddle_r;
    end
  end

  // State, lives, target, paddle and run_en registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      lives_r  <= 2'(LIVES);
      target_r <= X_MID;
      paddle_r <= X_MID;
      run_en_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      lives_r  <= lives_nxt_s;
      target_r <= target_nxt_s;
      paddle_r <= paddle_nxt_s;
      run_en_r <= (state_nxt_s == S_PLAY);
    end
  end

  assign bus.paddle_x   = paddle_r;
  assign bus.game_state = state_r;
  assign bus.run_en     = run_en_r;
  assign bus.lives      = lives_r;

endmodule

// File: tb/tb_game_key_ctrl.sv
// Self-checking bench for game_key_ctrl: directed scenarios plus randomized play against an integer game model.
module tb_game_key_ctrl;

  logic clk;
  logic rst_n;
  game_key_ctrl_if bif ();

  game_key_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks;
  int errors;

  // Behavioural game model: plain integers following the game rules.
  int m_st, m_lv, m_tg, m_px;
  int m_since, m_chain, m_last_right;

  task automatic model_reset();
    m_st = 0; m_lv = 3; m_tg = 280; m_px = 280;
    m_since = 0; m_chain = 0; m_last_right = 0;
  endtask

  task automatic model_step(input logic [3:0] k, input logic ft, input logic bm);
    int d, step, nt;
    bit pressed;
    if (k[3]) begin
      model_reset();
    end else begin
      pressed = 1'b0;
      if (m_st == 1 && ft) begin
        d = m_tg - m_px;
        if (d > 4) m_px = m_px + 4;
        else if (d < -4) m_px = m_px - 4;
        else m_px = m_tg;
      end
      if (k[2]) begin
        case (m_st)
          0: m_st = 1;
          1: m_st = 2;
          2: m_st = 1;
          default: m_st = 0;
        endcase
      end else if (bm && m_st == 1) begin
        if (m_lv <= 1) begin m_lv = 0; m_st = 3; end
        else m_lv = m_lv - 1;
      end else if (m_st == 1 && k[0] != k[1]) begin
        step = 16;
`ifdef PADDLE_ACCEL_EN
        if (m_chain != 0 && m_since < 15 && m_last_right == int'(k[1])) step = 32;
`endif
        if (k[0]) begin
          nt = m_tg - step;
          m_tg = (nt < 0) ? 0 : nt;
        end else begin
          nt = m_tg + step;
          m_tg = (nt > 560) ? 560 : nt;
        end
        pressed = 1'b1;
        m_since = 0; m_chain = 1; m_last_right = int'(k[1]);
      end
      if (m_st != 1) begin
        m_chain = 0; m_since = 0;
      end else if (!pressed && ft) begin
        m_since = m_since + 1;
      end
    end
  endtask

  task automatic tick(input logic [3:0] k, input logic ft, input logic bm);
    bif.key_pulse  = k;
    bif.frame_tick = ft;
    bif.ball_miss  = bm;
    @(posedge clk);
    model_step(k, ft, bm);
    #1;
    bif.key_pulse  = 4'b0000;
    bif.frame_tick = 1'b0;
    bif.ball_miss  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.key_pulse = 4'b0000; bif.frame_tick = 1'b0; bif.ball_miss = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.paddle_x !== 10'd280 || bif.game_state !== 2'd0 || bif.lives !== 2'd3 || bif.run_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got x=%0d st=%0d lv=%0d run=%0b want x=280 st=0 lv=3 run=0",
               bif.paddle_x, bif.game_state, bif.lives, bif.run_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    checks++;
    if (bif.paddle_x !== 10'd280 || bif.game_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_left_ignored: got x=%0d st=%0d want x=280 st=0", bif.paddle_x, bif.game_state);
    end
  endtask

  task automatic test_glide();
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(4'b0000, 1'b1, 1'b0);
      checks++;
      if (bif.paddle_x !== 10'(284 + 4 * i) || bif.run_en !== 1'b1) begin
        errors++;
        $display("FAIL glide_step%0d: got x=%0d run=%0b want x=%0d run=1", i, bif.paddle_x, bif.run_en, 284 + 4 * i);
      end
    end
    tick(4'b0000, 1'b1, 1'b0);
    checks++;
    if (bif.paddle_x !== 10'd296) begin
      errors++;
      $display("FAIL glide_settle: got x=%0d want x=296", bif.paddle_x);
    end
  endtask

  task automatic test_clamp_low();
    bit wrapped;
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    repeat (17) tick(4'b0001, 1'b0, 1'b0);
    repeat (2) tick(4'b0001, 1'b0, 1'b0);
    wrapped = 1'b0;
    repeat (80) begin
      tick(4'b0000, 1'b1, 1'b0);
      if (bif.paddle_x > 10'd560) wrapped = 1'b1;
    end
    checks++;
    if (bif.paddle_x !== 10'd0 || wrapped) begin
      errors++;
      $display("FAIL clamp_low: got x=%0d wrapped=%0b want x=0 wrapped=0", bif.paddle_x, wrapped);
    end
    repeat (10) tick(4'b0001, 1'b1, 1'b0);
    checks++;
    if (bif.paddle_x !== 10'd0) begin
      errors++;
      $display("FAIL clamp_low_hold: got x=%0d want x=0", bif.paddle_x);
    end
  endtask

  task automatic test_lives();
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b0, 1'b1);
      checks++;
      if (bif.lives !== 2'(2 - i)) begin
        errors++;
        $display("FAIL lives_after_miss%0d: got %0d want %0d", i, bif.lives, 2 - i);
      end
    end
    checks++;
    if (bif.game_state !== 2'd3 || bif.run_en !== 1'b0) begin
      errors++;
      $display("FAIL game_over: got st=%0d run=%0b want st=3 run=0", bif.game_state, bif.run_en);
    end
    tick(4'b0100, 1'b0, 1'b0);
    checks++;
    if (bif.game_state !== 2'd0 || bif.lives !== 2'd0) begin
      errors++;
      $display("FAIL over_to_idle: got st=%0d lv=%0d want st=0 lv=0", bif.game_state, bif.lives);
    end
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b1);
    checks++;
    if (bif.game_state !== 2'd2 || bif.lives !== 2'd3) begin
      errors++;
      $display("FAIL start_beats_miss: got st=%0d lv=%0d want st=2 lv=3", bif.game_state, bif.lives);
    end
  endtask

  task automatic test_pause_restart();
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    repeat (5) tick(4'b0010, 1'b1, 1'b0);
    checks++;
    if (bif.paddle_x !== 10'd284 || bif.game_state !== 2'd2 || bif.run_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_freeze: got x=%0d st=%0d run=%0b want x=284 st=2 run=0", bif.paddle_x, bif.game_state, bif.run_en);
    end
    tick(4'b1100, 1'b0, 1'b0);
    checks++;
    if (bif.game_state !== 2'd0 || bif.lives !== 2'd3 || bif.paddle_x !== 10'd280) begin
      errors++;
      $display("FAIL restart_beats_start: got st=%0d lv=%0d x=%0d want st=0 lv=3 x=280", bif.game_state, bif.lives, bif.paddle_x);
    end
  endtask

`ifdef PADDLE_ACCEL_EN
  task automatic test_accel();
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    repeat (5) tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    repeat (20) tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    repeat (10) tick(4'b0000, 1'b1, 1'b0);
    checks++;
    if (bif.paddle_x !== 10'd344) begin
      errors++;
      $display("FAIL accel_target: got x=%0d want x=344", bif.paddle_x);
    end
  endtask
`endif

  task automatic test_random();
    int r;
    logic [3:0] k;
    logic ft, bm;
    int bad;
    tick(4'b1000, 1'b0, 1'b0);
    bad = 0;
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      k = 4'b0000;
      if (r < 1) k[3] = 1'b1;
      if (r >= 1 && r < 6) k[2] = 1'b1;
      k[0] = ($urandom_range(0, 99) < 30);
      k[1] = ($urandom_range(0, 99) < 30);
      ft = ($urandom_range(0, 99) < 40);
      bm = ($urandom_range(0, 99) < 3);
      tick(k, ft, bm);
      checks++;
      if (bif.paddle_x !== 10'(m_px) || bif.game_state !== 2'(m_st) || bif.lives !== 2'(m_lv) ||
          bif.run_en !== (m_st == 1)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle%0d: got x=%0d st=%0d lv=%0d run=%0b want x=%0d st=%0d lv=%0d run=%0b",
                   n, bif.paddle_x, bif.game_state, bif.lives, bif.run_en, m_px, m_st, m_lv, (m_st == 1));
        bad++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_glide();
    test_clamp_low();
    test_lives();
    test_pause_restart();
`ifdef PADDLE_ACCEL_EN
    test_accel();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
